// File: rtl/dizi_karsilastirma_kontrol.sv
// Runs an equality comparison over a streamed DNA nucleotide-pair sequence and reports match,
// mismatch and first-mismatch index. Optional early abort on a mismatch threshold: ERKEN_DUR_EN.
module dizi_karsilastirma_kontrol #(
  parameter  int unsigned MAX_LEN = 256,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] uzunluk,
  input  logic             nuk_valid,
  output logic             nuk_ready,
  input  logic [1:0]       nukleotid1,
  input  logic [1:0]       nukleotid2,
  output logic [CNT_W-1:0] esleme_sayisi,
  output logic [CNT_W-1:0] fark_sayisi,
  output logic [CNT_W-1:0] ilk_fark,
  output logic             busy,
`ifdef ERKEN_DUR_EN
  input  logic [CNT_W-1:0] esik,
  output logic             erken_durdu,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] esleme_q, esleme_d;
  logic [CNT_W-1:0] fark_q, fark_d;
  logic [CNT_W-1:0] ilk_fark_q, ilk_fark_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ERKEN_DUR_EN
  logic             erken_q, erken_d;
`endif

  logic [CNT_W-1:0] len_clamp_c;
  logic             xfer_c;
  logic             esit_c;

  assign len_clamp_c = (uzunluk > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : uzunluk;
  assign xfer_c      = (state_q == S_RUN) && nuk_valid && ready_q;
  assign esit_c      = (nukleotid1 == nukleotid2);

  // Next-state and next-output logic; status outputs are derived from the next state
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    esleme_d   = esleme_q;
    fark_d     = fark_q;
    ilk_fark_d = ilk_fark_q;
`ifdef ERKEN_DUR_EN
    erken_d    = erken_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_clamp_c;
          idx_d      = '0;
          esleme_d   = '0;
          fark_d     = '0;
          ilk_fark_d = '0;
`ifdef ERKEN_DUR_EN
          erken_d    = 1'b0;
`endif
          state_d    = (len_clamp_c == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer_c) begin
          if (esit_c) begin
            esleme_d = esleme_q + CNT_W'(1);
          end else begin
            fark_d = fark_q + CNT_W'(1);
            if (fark_q == '0) begin
              ilk_fark_d = idx_q;
            end
          end
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == len_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end
`ifdef ERKEN_DUR_EN
          // Abort as soon as this transfer brings the mismatch count up to the threshold
          if ((esik != '0) && !esit_c && ((fark_q + CNT_W'(1)) == esik)) begin
            state_d = S_DONE;
            erken_d = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      esleme_q   <= '0;
      fark_q     <= '0;
      ilk_fark_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ERKEN_DUR_EN
      erken_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      esleme_q   <= esleme_d;
      fark_q     <= fark_d;
      ilk_fark_q <= ilk_fark_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ERKEN_DUR_EN
      erken_q    <= erken_d;
`endif
    end
  end

  assign nuk_ready     = ready_q;
  assign esleme_sayisi = esleme_q;
  assign fark_sayisi   = fark_q;
  assign ilk_fark      = ilk_fark_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef ERKEN_DUR_EN
  assign erken_durdu   = erken_q;
`endif

endmodule
